// File: rtl/max_search_sequencer.sv
// Burst maximum/index finder that time-shares one external registered comparator.
// Used to pick the block exponent for the fixed-to-float conversion path.
module max_search_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] max_out,
  output logic [IDX_W-1:0] max_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRST   = 3'd1,
    S_ACCEPT  = 3'd2,
    S_COMPARE = 3'd3,
    S_EVAL    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_cand;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_cmp_a;
  logic [WIDTH-1:0] r_cmp_b;
  logic [WIDTH-1:0] r_max_out;
  logic [IDX_W-1:0] r_max_idx;

  // in_ready/busy are registered copies of the next-state decode, so they
  // always equal the decode of the current state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_max      <= '0;
      r_cand     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cmp_a    <= '0;
      r_cmp_b    <= '0;
      r_max_out  <= '0;
      r_max_idx  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FIRST;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FIRST: begin
          if (in_valid) begin
            r_max <= in_data;
            r_idx <= '0;
            if (COUNT == 1) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              r_cnt   <= IDX_W'(1);
              r_state <= S_ACCEPT;
            end
          end
        end
        S_ACCEPT: begin
          // Comparator operands are loaded here so they are stable through COMPARE.
          if (in_valid) begin
            r_cand     <= in_data;
            r_cmp_a    <= in_data;
            r_cmp_b    <= r_max;
            r_in_ready <= 1'b0;
            r_state    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          // Strict greater-than: an equal later word keeps the earlier index.
          if (cmp_gt) begin
            r_max <= r_cand;
            r_idx <= r_cnt;
          end
          if (r_cnt == LAST_IDX) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt      <= r_cnt + IDX_W'(1);
            r_in_ready <= 1'b1;
            r_state    <= S_ACCEPT;
          end
        end
        S_DONE: begin
          r_max_out <= r_max;
          r_max_idx <= r_idx;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cmp_a    = r_cmp_a;
  assign cmp_b    = r_cmp_b;
  assign max_out  = r_max_out;
  assign max_idx  = r_max_idx;

endmodule

// File: tb/tb_max_search_sequencer.sv
// Self-checking bench: random and directed bursts against a plain max/argmax model.
module tb_max_search_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  typedef logic [W-1:0] burst_t [N];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic [W-1:0]  cmp_a, cmp_b;
  logic          cmp_gt;
  logic [W-1:0]  max_out;
  logic [IW-1:0] max_idx;
  logic          busy, done;

  logic          start1 = 1'b0;
  logic          in_valid1 = 1'b0;
  logic [W-1:0]  in_data1 = '0;
  logic          in_ready1;
  logic [W-1:0]  cmp_a1, cmp_b1;
  logic          cmp_gt1;
  logic [W-1:0]  max_out1;
  logic [0:0]    max_idx1;
  logic          busy1, done1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] prev_max = '0;

  // External registered comparators (environment, one per instance).
  always @(posedge clk) cmp_gt  <= (cmp_a  > cmp_b);
  always @(posedge clk) cmp_gt1 <= (cmp_a1 > cmp_b1);
  always @(posedge clk) cyc <= cyc + 1;

  max_search_sequencer #(.WIDTH(W), .COUNT(N), .IDX_W(IW)) dut (
    .CLK(clk), .RST(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt),
    .max_out(max_out), .max_idx(max_idx), .busy(busy), .done(done)
  );

  max_search_sequencer #(.WIDTH(W), .COUNT(1), .IDX_W(1)) dut1 (
    .CLK(clk), .RST(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_gt(cmp_gt1),
    .max_out(max_out1), .max_idx(max_idx1), .busy(busy1), .done(done1)
  );

  // Reference: maximum value, earliest position on ties.
  function automatic void ref_max(input burst_t w, output logic [W-1:0] m, output logic [IW-1:0] idx);
    m = w[0];
    idx = '0;
    for (int i = 1; i < N; i++) begin
      if (w[i] > m) begin
        m = w[i];
        idx = IW'(i);
      end
    end
  endfunction

  // Offer one word; optional valid gaps, junk while not ready, stray start pulses.
  task automatic feed_word(input logic [W-1:0] v, input bit gaps, input bit junk,
                           input bit mid_start, output bit ok);
    int guard = 0;
    ok = 1'b0;
    while (guard < 60) begin
      if (in_ready && !(gaps && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        ok       = 1'b1;
        return;
      end
      in_valid = (!in_ready && junk) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = (!in_ready && junk) ? 8'hFF : 8'($urandom);
      start    = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      guard++;
    end
    n_checks++;
    n_fail++;
    $display("FAIL feed_word_timeout: in_ready=%0b required 1 within 60 cycles", in_ready);
  endtask

  task automatic run_burst(input burst_t w, input bit gaps, input bit junk, input bit mid_start,
                           input bit dstart, output int lat_last, output int lat_total,
                           output logic [W-1:0] got_max, output logic [IW-1:0] got_idx,
                           output logic [W-1:0] held_max, output logic bsy,
                           output logic done_next, output bit ok);
    int  first_cyc = 0;
    bit  okw;
    ok = 1'b0;
    lat_last = 0;
    lat_total = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      feed_word(w[i], gaps, junk, mid_start, okw);
      if (!okw) return;
      if (i == 0) first_cyc = cyc;
    end
    held_max = max_out;
    while (!done && lat_last < 40) begin
      start    = dstart && (lat_last == 2);
      in_valid = junk;
      in_data  = 8'hFF;
      @(negedge clk);
      lat_last++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done=%0b required 1 within 40 cycles", done);
      return;
    end
    lat_total = cyc - first_cyc;
    got_max   = max_out;
    got_idx   = max_idx;
    bsy       = busy;
    @(negedge clk);
    done_next = done;
    ok = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", done); end
    n_checks++; if (max_out !== 8'h00) begin n_fail++; $display("FAIL reset_max_out: got %h need 00", max_out); end
    n_checks++; if (max_idx !== 3'd0) begin n_fail++; $display("FAIL reset_max_idx: got %0d need 0", max_idx); end
    n_checks++; if (cmp_a !== 8'h00 || cmp_b !== 8'h00) begin n_fail++; $display("FAIL reset_cmp: got a=%h b=%h need 00/00", cmp_a, cmp_b); end
    n_checks++; if (busy1 !== 1'b0 || in_ready1 !== 1'b0 || max_out1 !== 8'h00) begin
      n_fail++; $display("FAIL reset_count1: got busy=%b rdy=%b max=%h need 0/0/00", busy1, in_ready1, max_out1);
    end
    prev_max = '0;
  endtask

  // Directed burst with held valid: result, latency and pulse shape.
  task automatic test_directed(input string name, input burst_t w);
    int lat_last, lat_total;
    logic [W-1:0] gm, hm, em;
    logic [IW-1:0] gi, ei;
    logic bsy, dn;
    bit ok;
    ref_max(w, em, ei);
    run_burst(w, 1'b0, 1'b0, 1'b0, 1'b0, lat_last, lat_total, gm, gi, hm, bsy, dn, ok);
    if (!ok) return;
    n_checks++; if (gm !== em) begin n_fail++; $display("FAIL %s_max: got %h need %h", name, gm, em); end
    n_checks++; if (gi !== ei) begin n_fail++; $display("FAIL %s_idx: got %0d need %0d", name, gi, ei); end
    n_checks++; if (lat_last != 3) begin n_fail++; $display("FAIL %s_done_latency: got %0d need 3", name, lat_last); end
    n_checks++; if (lat_total != 22) begin n_fail++; $display("FAIL %s_total_latency: got %0d need 22", name, lat_total); end
    n_checks++; if (hm !== prev_max) begin n_fail++; $display("FAIL %s_held_max: got %h need %h", name, hm, prev_max); end
    n_checks++; if (dn !== 1'b0 || bsy !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got done_next=%b busy=%b need 0/0", name, dn, bsy); end
    prev_max = em;
  endtask

  task automatic test_gaps_and_start;
    int lat_last, lat_total, extra;
    logic [W-1:0] gm, hm, em;
    logic [IW-1:0] gi, ei;
    logic bsy, dn;
    bit ok;
    burst_t w;
    for (int i = 0; i < N; i++) w[i] = 8'($urandom_range(0, 200));
    ref_max(w, em, ei);
    run_burst(w, 1'b1, 1'b1, 1'b1, 1'b1, lat_last, lat_total, gm, gi, hm, bsy, dn, ok);
    if (!ok) return;
    n_checks++; if (gm !== em || gi !== ei) begin n_fail++; $display("FAIL gaps_result: got %h/%0d need %h/%0d", gm, gi, em, ei); end
    n_checks++; if (lat_last != 3) begin n_fail++; $display("FAIL gaps_done_latency: got %0d need 3", lat_last); end
    extra = 0;
    repeat (6) begin
      if (busy || in_ready || done) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL gaps_second_burst: got %0d active cycles need 0", extra); end
    prev_max = em;
  endtask

  task automatic test_random;
    int lat_last, lat_total;
    logic [W-1:0] gm, hm, em;
    logic [IW-1:0] gi, ei;
    logic bsy, dn;
    bit ok;
    burst_t w;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) w[i] = 8'($urandom_range(0, (r % 2 == 1) ? 255 : 7));
      ref_max(w, em, ei);
      run_burst(w, (r % 3 == 0), (r % 4 == 1), 1'b0, 1'b0, lat_last, lat_total, gm, gi, hm, bsy, dn, ok);
      if (!ok) return;
      n_checks++; if (gm !== em || gi !== ei) begin n_fail++; $display("FAIL random_%0d_result: got %h/%0d need %h/%0d", r, gm, gi, em, ei); end
      n_checks++; if (hm !== prev_max) begin n_fail++; $display("FAIL random_%0d_held: got %h need %h", r, hm, prev_max); end
      prev_max = em;
    end
  endtask

  task automatic test_mid_reset;
    bit okw;
    int seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      feed_word(8'(10 + i), 1'b0, 1'b0, 1'b0, okw);
      if (!okw) return;
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b rdy=%b need 0/0", busy, in_ready); end
    n_checks++; if (max_out !== 8'h00 || max_idx !== 3'd0) begin n_fail++; $display("FAIL midrst_result: got %h/%0d need 00/0", max_out, max_idx); end
    repeat (10) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles need 0", seen); end
    prev_max = '0;
  endtask

  task automatic test_count1;
    int k = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (!in_ready1 && k < 10) begin @(negedge clk); k++; end
    in_valid1 = 1'b1;
    in_data1  = 8'd5;
    @(negedge clk);
    in_valid1 = 1'b0;
    in_data1  = 8'd99;
    k = 0;
    while (!done1 && k < 10) begin @(negedge clk); k++; end
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL count1_done: got %b need 1", done1); end
    n_checks++; if (max_out1 !== 8'd5 || max_idx1 !== 1'b0) begin n_fail++; $display("FAIL count1_result: got %h/%0d need 05/0", max_out1, max_idx1); end
    @(negedge clk);
    n_checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL count1_pulse: got done=%b busy=%b need 0/0", done1, busy1); end
  endtask

  initial begin
    burst_t b;
    @(negedge clk);
    test_reset();
    b = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd0, 8'd7, 8'd2, 8'd8};
    test_directed("tie", b);
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    test_directed("ascending", b);
    b = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    test_directed("ff_first", b);
    b = '{8'h7F, 8'h80, 8'h7F, 8'h00, 8'h01, 8'h7E, 8'h80, 8'h10};
    test_directed("unsigned", b);
    test_gaps_and_start();
    test_random();
    test_mid_reset();
    b = '{8'd4, 8'd40, 8'd7, 8'd40, 8'd41, 8'd0, 8'd2, 8'd41};
    test_directed("after_reset", b);
    test_count1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
